// File: rtl/int_inject_sched.sv
// PC-triggered one-shot interrupt injector for the P7 MIPS harness: table match -> delay -> hold.
// Define INT_INJECT_SCHED_STATS_EN to add the fire_count / miss_count outputs.
module int_inject_sched #(
  parameter int ENTRIES = 32,
  parameter int IDXW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [31:0]     addr,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [31:0]     cfg_addr,
  input  logic [7:0]      cfg_delay,
  input  logic [7:0]      cfg_hold,
  input  logic            cfg_clr,
  output logic            interrupt,
  output logic            busy,
  output logic [IDXW-1:0] fired_idx,
  output logic            done
`ifdef INT_INJECT_SCHED_STATS_EN
  ,
  output logic [15:0]     fire_count,
  output logic [15:0]     miss_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ASSERT = 2'd2
  } state_t;

  localparam logic [IDXW:0] ENTRIES_W = (IDXW+1)'(ENTRIES);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      hold_q, hold_d;
  logic            interrupt_q, interrupt_d;
  logic [IDXW-1:0] fired_idx_q, fired_idx_d;
  logic            done_pend_q, done_pend_d;
  logic            done_q, done_d;
  logic [ENTRIES-1:0] valid_q, valid_d;

  logic [31:0] tbl_addr_q  [ENTRIES];
  logic [31:0] tbl_addr_d  [ENTRIES];
  logic [7:0]  tbl_delay_q [ENTRIES];
  logic [7:0]  tbl_delay_d [ENTRIES];
  logic [7:0]  tbl_hold_q  [ENTRIES];
  logic [7:0]  tbl_hold_d  [ENTRIES];

  logic [ENTRIES-1:0] hit_vec;
  logic               hit_any;
  logic [IDXW-1:0]    hit_idx;
  logic [7:0]         hit_delay;
  logic [7:0]         hit_hold;
  logic [7:0]         eff_delay;
  logic               wr_en;
  logic               fire_now;

  assign wr_en = cfg_we && ({1'b0, cfg_idx} < ENTRIES_W);

  // Per-entry comparators always look at pre-write table contents.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_hit
      assign hit_vec[gi] = valid_q[gi] && (tbl_addr_q[gi] == addr);
    end
  endgenerate

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  assign hit_delay = tbl_delay_q[hit_idx];
  assign hit_hold  = tbl_hold_q[hit_idx];
  assign eff_delay = (hit_delay == 8'd0) ? 8'd1 : hit_delay;

  always_comb begin
    tbl_addr_d  = tbl_addr_q;
    tbl_delay_d = tbl_delay_q;
    tbl_hold_d  = tbl_hold_q;
    if (wr_en) begin
      tbl_addr_d[cfg_idx]  = cfg_addr;
      tbl_delay_d[cfg_idx] = cfg_delay;
      tbl_hold_d[cfg_idx]  = cfg_hold;
    end
  end

  always_ff @(posedge clk) begin
    tbl_addr_q  <= tbl_addr_d;
    tbl_delay_q <= tbl_delay_d;
    tbl_hold_q  <= tbl_hold_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    interrupt_d = interrupt_q;
    fired_idx_d = fired_idx_q;
    done_pend_d = 1'b0;
    done_d      = done_pend_q;
    valid_d     = valid_q;
    fire_now    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && hit_any) begin
          fire_now             = 1'b1;
          valid_d[hit_idx]     = 1'b0;
          fired_idx_d          = hit_idx;
          hold_d               = hit_hold;
          if (eff_delay == 8'd1) begin
            state_d     = S_ASSERT;
            interrupt_d = 1'b1;
            cnt_d       = hit_hold;
          end else begin
            state_d = S_DELAY;
            cnt_d   = eff_delay - 8'd1;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == 8'd1) begin
          state_d     = S_ASSERT;
          interrupt_d = 1'b1;
          cnt_d       = hold_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ASSERT: begin
        if (cnt_q == 8'd0) begin
          state_d     = S_IDLE;
          interrupt_d = 1'b0;
          done_pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        interrupt_d = 1'b0;
      end
    endcase

    // Clear then write: a same-cycle write to a firing entry leaves it valid.
    if (cfg_clr) valid_d = '0;
    if (wr_en) valid_d[cfg_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      interrupt_q <= 1'b0;
      fired_idx_q <= '0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      interrupt_q <= interrupt_d;
      fired_idx_q <= fired_idx_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
    end
  end

  assign interrupt = interrupt_q;
  assign busy      = (state_q != S_IDLE);
  assign fired_idx = fired_idx_q;
  assign done      = done_q;

`ifdef INT_INJECT_SCHED_STATS_EN
  logic [15:0] fire_count_q, fire_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  always_comb begin
    fire_count_d = fire_count_q + 16'(fire_now);
    miss_count_d = miss_count_q;
    if (busy && (|hit_vec) && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire_count_q <= '0;
      miss_count_q <= '0;
    end else begin
      fire_count_q <= fire_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign fire_count = fire_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_fire_now;
  assign unused_fire_now = fire_now;
`endif

endmodule

// File: tb/tb_int_inject_sched.sv
// Self-checking bench for int_inject_sched: directed test-plan steps then random traffic vs a window model.
module tb_int_inject_sched;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] addr;
  logic        cfg_we;
  logic [4:0]  cfg_idx;
  logic [31:0] cfg_addr;
  logic [7:0]  cfg_delay;
  logic [7:0]  cfg_hold;
  logic        cfg_clr;
  logic        interrupt;
  logic        busy;
  logic [4:0]  fired_idx;
  logic        done;
`ifdef INT_INJECT_SCHED_STATS_EN
  logic [15:0] fire_count;
  logic [15:0] miss_count;
`endif

  int_inject_sched #(.ENTRIES(32), .IDXW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .addr      (addr),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_addr  (cfg_addr),
    .cfg_delay (cfg_delay),
    .cfg_hold  (cfg_hold),
    .cfg_clr   (cfg_clr),
    .interrupt (interrupt),
    .busy      (busy),
    .fired_idx (fired_idx),
    .done      (done)
`ifdef INT_INJECT_SCHED_STATS_EN
    ,
    .fire_count(fire_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hi_cnt   = 0;

  // Reference model: table contents plus the time window of the sequence in flight.
  logic        m_valid [32];
  logic [31:0] m_addr  [32];
  logic [7:0]  m_delay [32];
  logic [7:0]  m_hold  [32];
  int          fire_cyc, win_start, win_end;
  int          done_list [$];
  logic [4:0]  m_fired;
  logic [15:0] m_fire, m_miss;

  logic [31:0] pool [8] = '{32'h3000, 32'h3004, 32'h3008, 32'h300c,
                            32'h3010, 32'h3014, 32'h3018, 32'h301c};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    fire_cyc  = -1000;
    win_start = -1000;
    win_end   = -1000;
    done_list.delete();
    m_fired = '0;
    m_fire  = '0;
    m_miss  = '0;
  endtask

  // One clock cycle: check outputs for cycle cyc, drive its inputs, advance the model.
  task automatic step(input logic en, input logic [31:0] a, input logic we,
                      input logic [4:0] idx, input logic [31:0] ca,
                      input logic [7:0] cd, input logic [7:0] ch, input logic clr);
    logic busy_c;
    logic exp_done;
    int   hit;
    int   d;
    busy_c   = (cyc > fire_cyc) && (cyc <= win_end);
    exp_done = (done_list.size() > 0) && (done_list[0] == cyc);
    chk("interrupt", {31'd0, interrupt}, {31'd0, (cyc >= win_start) && (cyc <= win_end)});
    chk("busy", {31'd0, busy}, {31'd0, busy_c});
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("fired_idx", {27'd0, fired_idx}, {27'd0, m_fired});
`ifdef INT_INJECT_SCHED_STATS_EN
    chk("fire_count", {16'd0, fire_count}, {16'd0, m_fire});
    chk("miss_count", {16'd0, miss_count}, {16'd0, m_miss});
`endif
    if (interrupt === 1'b1) hi_cnt++;
    while (done_list.size() > 0 && done_list[0] <= cyc) void'(done_list.pop_front());

    enable = en; addr = a; cfg_we = we; cfg_idx = idx;
    cfg_addr = ca; cfg_delay = cd; cfg_hold = ch; cfg_clr = clr;

    hit = -1;
    for (int i = 0; i < 32; i++) begin
      if (hit < 0 && m_valid[i] && m_addr[i] == a) hit = i;
    end
    if (busy_c) begin
      if (hit >= 0 && m_miss != 16'hFFFF) m_miss++;
    end else if (en && hit >= 0) begin
      d = (m_delay[hit] == 8'd0) ? 1 : int'(m_delay[hit]);
      fire_cyc  = cyc;
      win_start = cyc + d;
      win_end   = cyc + d + int'(m_hold[hit]);
      done_list.push_back(win_end + 2);
      m_fired      = 5'(hit);
      m_valid[hit] = 1'b0;
      m_fire++;
    end
    if (clr) for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    if (we) begin
      m_valid[idx] = 1'b1;
      m_addr[idx]  = ca;
      m_delay[idx] = cd;
      m_hold[idx]  = ch;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] ca, input logic [7:0] cd, input logic [7:0] ch);
    step(1'b1, 32'h0, 1'b1, idx, ca, cd, ch, 1'b0);
  endtask

  task automatic visit(input logic [31:0] a);
    step(1'b1, a, 1'b0, 5'd0, 32'h0, 8'd0, 8'd0, 1'b0);
  endtask

  logic        r_en, r_we, r_clr;
  logic [31:0] r_a, r_ca;
  logic [4:0]  r_idx;
  logic [7:0]  r_cd, r_ch;
  int          hi0;

  initial begin
    reset = 1'b0; enable = 1'b0; addr = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_addr = '0; cfg_delay = '0; cfg_hold = '0; cfg_clr = 1'b0;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      m_addr[i] = '0; m_delay[i] = '0; m_hold[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_interrupt", {31'd0, interrupt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fired_idx", {27'd0, fired_idx}, 32'd0);
    reset = 1'b1;

    // Single fire of entry0, then a second visit is ignored.
    wr(5'd0, 32'h3090, 8'd1, 8'd5);
    idle(2);
    hi0 = hi_cnt;
    visit(32'h3090);
    idle(10);
    chk("entry0_high_cycles", hi_cnt - hi0, 32'd6);
    hi0 = hi_cnt;
    visit(32'h3090);
    idle(6);
    chk("entry0_oneshot", hi_cnt - hi0, 32'd0);

    // Lowest index wins; the other entry fires on a later visit.
    wr(5'd3, 32'h3168, 8'd3, 8'd5);
    wr(5'd1, 32'h3168, 8'd1, 8'd0);
    visit(32'h3168);
    idle(4);
    visit(32'h3168);
    idle(12);

    // Match while busy is a miss; entry2 survives and fires after done.
    wr(5'd2, 32'h30c0, 8'd2, 8'd4);
    wr(5'd4, 32'h3200, 8'd1, 8'd3);
    visit(32'h3200);
    idle(1);
    visit(32'h30c0);
    idle(6);
    visit(32'h30c0);
    idle(10);

    // delay=0 behaves as delay=1.
    wr(5'd6, 32'h3300, 8'd0, 8'd0);
    visit(32'h3300);
    idle(4);

    // enable low blocks; same-cycle write to the matching entry keeps it valid.
    wr(5'd7, 32'h3400, 8'd2, 8'd1);
    step(1'b0, 32'h3400, 1'b0, 5'd0, 32'h0, 8'd0, 8'd0, 1'b0);
    idle(3);
    step(1'b1, 32'h3400, 1'b1, 5'd7, 32'h3400, 8'd4, 8'd2, 1'b0);
    idle(8);
    visit(32'h3400);
    idle(10);

    // Reset mid-ASSERT drops interrupt at once and invalidates the table.
    wr(5'd8, 32'h3500, 8'd1, 8'd6);
    wr(5'd9, 32'h3408, 8'd1, 8'd0);
    visit(32'h3500);
    idle(2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_interrupt", {31'd0, interrupt}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b1;
    visit(32'h3408);
    idle(3);

    // Clear plus write in one cycle leaves only the written entry valid.
    wr(5'd10, 32'h3700, 8'd1, 8'd0);
    step(1'b1, 32'h0, 1'b1, 5'd5, 32'h3600, 8'd1, 8'd0, 1'b1);
    visit(32'h3700);
    idle(3);
    visit(32'h3600);
    idle(4);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      r_en  = ($urandom_range(0, 9) != 0);
      r_a   = ($urandom_range(0, 3) == 0) ? 32'h0 : pool[$urandom_range(0, 7)];
      r_we  = ($urandom_range(0, 3) == 0);
      r_idx = 5'($urandom_range(0, 11));
      r_ca  = pool[$urandom_range(0, 7)];
      r_cd  = 8'($urandom_range(0, 4));
      r_ch  = 8'($urandom_range(0, 3));
      r_clr = ($urandom_range(0, 79) == 0);
      step(r_en, r_a, r_we, r_idx, r_ca, r_cd, r_ch, r_clr);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
